// File: rtl/fcmp_sched.sv
// Time-shares one registered float less-than unit among NREQ requesters.
// FLT is one pass, FLE is one swapped pass, FEQ is two passes; one op in flight at a time.
module fcmp_sched #(
    parameter int NREQ    = 4,
    parameter int CMP_LAT = 1,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_x1,
    input  logic [NREQ*32-1:0] req_x2,
    input  logic [NREQ*2-1:0]  req_op,
    output logic [31:0]        cmp_x1,
    output logic [31:0]        cmp_x2,
    input  logic [31:0]        cmp_y,
    output logic               resp_valid,
    output logic [IDW-1:0]     resp_id,
    output logic [31:0]        resp_y,
    output logic               busy
);
    localparam int CW = $clog2(CMP_LAT + 2);
    localparam logic [1:0] OP_FLE = 2'b01;
    localparam logic [1:0] OP_FEQ = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    typedef enum logic [2:0] {IDLE, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    x1_q, x1_d, x2_q, x2_d;
    logic [1:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ra_q, ra_d;
    logic [31:0]    cmp_x1_q, cmp_x1_d, cmp_x2_q, cmp_x2_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [31:0]    resp_y_q, resp_y_d;

    logic [31:0]    x1_arr [NREQ];
    logic [31:0]    x2_arr [NREQ];
    logic [1:0]     op_arr [NREQ];
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           unused_cmp_y_bits;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign x1_arr[gi] = req_x1[32*gi +: 32];
        assign x2_arr[gi] = req_x2[32*gi +: 32];
        assign op_arr[gi] = req_op[2*gi +: 2];
    end

    assign unused_cmp_y_bits = ^cmp_y[31:1];

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    assign req_ready = (state_q == IDLE && win_found) ? (NREQ'(1) << win_id) : '0;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        ra_d         = ra_q;
        cmp_x1_d     = cmp_x1_q;
        cmp_x2_d     = cmp_x2_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_y_d     = resp_y_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    x1_d  = x1_arr[win_id];
                    x2_d  = x2_arr[win_id];
                    op_d  = op_arr[win_id];
                    id_d  = win_id;
                    ptr_d = win_id;
                    if (op_arr[win_id] == OP_INV) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_id_d    = win_id;
                        resp_y_d     = '0;
                    end else begin
                        // Pass-A operands are registered on the accept edge and presented during ISSUE_A.
                        state_d  = ISSUE_A;
                        cmp_x1_d = (op_arr[win_id] == OP_FLE) ? x2_arr[win_id] : x1_arr[win_id];
                        cmp_x2_d = (op_arr[win_id] == OP_FLE) ? x1_arr[win_id] : x2_arr[win_id];
                    end
                end
            end
            ISSUE_A: begin
                state_d = WAIT_A;
                cnt_d   = '0;
            end
            WAIT_A: begin
                if (cnt_q == CW'(CMP_LAT - 1)) begin
                    ra_d = cmp_y[0];
                    if (op_q == OP_FEQ) begin
                        state_d = ISSUE_B;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_id_d    = id_q;
                        resp_y_d     = {31'b0, (op_q == OP_FLE) ? ~cmp_y[0] : cmp_y[0]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE_B: begin
                state_d  = WAIT_B;
                cnt_d    = '0;
                cmp_x1_d = x2_q;
                cmp_x2_d = x1_q;
            end
            WAIT_B: begin
                // Pass-B operands land one edge later than pass A, so this wait is one cycle longer.
                if (cnt_q == CW'(CMP_LAT)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_y_d     = {31'b0, ~ra_q & ~cmp_y[0]};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= IDW'(NREQ - 1);
            id_q         <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            ra_q         <= 1'b0;
            cmp_x1_q     <= '0;
            cmp_x2_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            ra_q         <= ra_d;
            cmp_x1_q     <= cmp_x1_d;
            cmp_x2_q     <= cmp_x2_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_y_q     <= resp_y_d;
        end
    end

    assign cmp_x1     = cmp_x1_q;
    assign cmp_x2     = cmp_x2_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_y     = resp_y_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fcmp_sched.sv
// Bench for fcmp_sched: directed table, round-robin and reset sequences, then random ops
// checked against a value-level model of FLT/FLE/FEQ and round-robin arbitration.
module tb_fcmp_sched;
    localparam int NREQ    = 4;
    localparam int CMP_LAT = 1;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_x1;
    logic [NREQ*32-1:0]  req_x2;
    logic [NREQ*2-1:0]   req_op;
    logic [31:0]         cmp_x1, cmp_x2, cmp_y;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_y;
    logic                busy;

    always #5 clk = ~clk;

    fcmp_sched #(.NREQ(NREQ), .CMP_LAT(CMP_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_op(req_op),
        .cmp_x1(cmp_x1), .cmp_x2(cmp_x2), .cmp_y(cmp_y),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y), .busy(busy)
    );

    // Float value ordering with exponent-0 values treated as zero (so +0 == -0).
    function automatic logic flt_lt(input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        ka = (a[30:23] == 8'd0) ? 0 : (a[31] ? -longint'(a[30:0]) : longint'(a[30:0]));
        kb = (b[30:23] == 8'd0) ? 0 : (b[31] ? -longint'(b[30:0]) : longint'(b[30:0]));
        return ka < kb;
    endfunction

    // Compare unit: CMP_LAT register stages behind the operand inputs.
    logic cmp_pipe [CMP_LAT];
    always @(posedge clk) begin
        cmp_pipe[0] <= flt_lt(cmp_x1, cmp_x2);
        for (int i = 1; i < CMP_LAT; i++) cmp_pipe[i] <= cmp_pipe[i-1];
    end
    assign cmp_y = {31'h2AAA_AAAA, cmp_pipe[CMP_LAT-1]};

    function automatic logic [31:0] model_y(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return {31'b0, flt_lt(a, b)};
            2'b01:   return {31'b0, !flt_lt(b, a)};
            2'b10:   return {31'b0, !flt_lt(a, b) && !flt_lt(b, a)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op);
        case (op)
            2'b11:   return 1;
            2'b10:   return 4 + 2 * CMP_LAT;
            default: return 2 + CMP_LAT;
        endcase
    endfunction

    int checks = 0;
    int errors = 0;
    int rr_ptr;
    logic [31:0] last_c1, last_c2;
    logic [31:0] tx1 [NREQ];
    logic [31:0] tx2 [NREQ];
    logic [1:0]  top [NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic load_inputs(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            req_x1[32*i +: 32] = tx1[i];
            req_x2[32*i +: 32] = tx2[i];
            req_op[2*i +: 2]   = top[i];
        end
        req_valid = mask;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rr_ptr = NREQ - 1;
        last_c1 = '0;
        last_c2 = '0;
    endtask

    // One request round: grant, latency, response fields, held compare operands, one-cycle pulse.
    task automatic run_txn(input logic [NREQ-1:0] mask, input logic use_model,
                           input logic [31:0] ey_tab, input string tag);
        int w, n, lat;
        logic got;
        logic [31:0] ey;
        @(negedge clk);
        load_inputs(mask);
        #1;
        w = pick(mask);
        check({tag, " grant"}, {28'b0, req_ready}, 32'(1 << w));
        ey  = use_model ? model_y(top[w], tx1[w], tx2[w]) : ey_tab;
        lat = model_lat(top[w]);
        if (top[w] == 2'b00 || top[w] == 2'b11) begin
            if (top[w] == 2'b00) begin last_c1 = tx1[w]; last_c2 = tx2[w]; end
        end else begin
            last_c1 = tx2[w]; last_c2 = tx1[w];
        end
        rr_ptr = w;
        @(negedge clk);
        req_valid = '0;
        n = 1;
        got = 1'b0;
        while (n <= 40 && !got) begin
            if (resp_valid) got = 1'b1;
            else begin @(negedge clk); n++; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout: no resp_valid within 40 cycles, required at cycle %0d", tag, lat);
        end else begin
            check({tag, " latency"}, 32'(n), 32'(lat));
            check({tag, " resp_id"}, 32'(resp_id), 32'(w));
            check({tag, " resp_y"}, resp_y, ey);
            check({tag, " cmp_x1"}, cmp_x1, last_c1);
            check({tag, " cmp_x2"}, cmp_x2, last_c2);
            check({tag, " busy in resp"}, 32'(busy), 32'd1);
            $display("txn %s: id=%0d op=%0d x1=%08h x2=%08h y=%0d lat=%0d", tag, w, top[w], tx1[w], tx2[w], resp_y, n);
            @(negedge clk);
            check({tag, " pulse end"}, 32'(resp_valid), 32'd0);
            check({tag, " resp_y hold"}, resp_y, ey);
            check({tag, " idle"}, 32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y;
    } vec_t;

    vec_t vecs [10];
    logic [31:0] pool [8];

    initial begin
        int k, n, gnt_exp, last_resp;
        logic saw;
        logic [NREQ-1:0] m;

        vecs[0] = '{0, 2'b00, 32'h3F800000, 32'h40000000, 32'd1};
        vecs[1] = '{2, 2'b10, 32'h80000000, 32'h00000000, 32'd1};
        vecs[2] = '{2, 2'b10, 32'h3F800000, 32'h3F800001, 32'd0};
        vecs[3] = '{1, 2'b01, 32'hC0400000, 32'hC0400000, 32'd1};
        vecs[4] = '{1, 2'b01, 32'h40400000, 32'h3F800000, 32'd0};
        vecs[5] = '{3, 2'b11, 32'h12345678, 32'h9ABCDEF0, 32'd0};
        vecs[6] = '{0, 2'b00, 32'h40000000, 32'h3F800000, 32'd0};
        vecs[7] = '{3, 2'b10, 32'hC0400000, 32'hC0400000, 32'd1};
        vecs[8] = '{1, 2'b01, 32'hBF800000, 32'h3F800000, 32'd1};
        vecs[9] = '{0, 2'b00, 32'h80000000, 32'h00000000, 32'd0};
        pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                 32'h40000000, 32'h00400000, 32'h7FC00000, 32'hFF800000};

        req_x1 = '0; req_x2 = '0; req_op = '0; req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin tx1[i] = '0; tx2[i] = '0; top[i] = '0; end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset req_ready", {28'b0, req_ready}, 32'd0);
        check("reset cmp_x1", cmp_x1, 32'd0);
        check("reset cmp_x2", cmp_x2, 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_id", 32'(resp_id), 32'd0);
        check("reset resp_y", resp_y, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            tx1[vecs[i].id] = vecs[i].x1;
            tx2[vecs[i].id] = vecs[i].x2;
            top[vecs[i].id] = vecs[i].op;
            run_txn(NREQ'(1 << vecs[i].id), 1'b0, vecs[i].y, $sformatf("vec%0d", i));
        end

        // All requesters valid continuously: grants rotate 0,1,2,3,0 back to back.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            tx1[i] = pool[$urandom_range(0, 7)];
            tx2[i] = pool[$urandom_range(0, 7)];
            top[i] = 2'b00;
        end
        @(negedge clk);
        load_inputs('1);
        #1;
        k = 0; n = 0; gnt_exp = 0; last_resp = -1;
        while (k < 5 && n < 100) begin
            if (req_ready != '0) begin
                check("rr grant", {28'b0, req_ready}, 32'(1 << gnt_exp));
                gnt_exp = (gnt_exp + 1) % NREQ;
            end
            if (resp_valid) begin
                check("rr resp_id", 32'(resp_id), 32'(k % NREQ));
                check("rr resp_y", resp_y, model_y(2'b00, tx1[k % NREQ], tx2[k % NREQ]));
                if (last_resp >= 0) check("rr spacing", 32'(n - last_resp), 32'(3 + CMP_LAT));
                $display("txn rr: id=%0d y=%0d cycle=%0d", resp_id, resp_y, n);
                last_resp = n;
                k++;
                if (k == 5) req_valid = '0;
            end
            @(negedge clk);
            #1;
            n++;
        end
        if (k < 5) begin
            checks++; errors++;
            $display("FAIL rr timeout: got %0d responses, required 5", k);
        end
        req_valid = '0;

        // Reset in WAIT_B of an FEQ: op dropped, state cleared, priority back to requester 0.
        do_reset();
        @(negedge clk);
        tx1[2] = 32'h3F800000; tx2[2] = 32'h3F800000; top[2] = 2'b10;
        load_inputs(4'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("rstB busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstB busy", 32'(busy), 32'd0);
        check("rstB cmp_x1", cmp_x1, 32'd0);
        check("rstB cmp_x2", cmp_x2, 32'd0);
        check("rstB resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (8) begin @(negedge clk); if (resp_valid) saw = 1'b1; end
        check("rstB no resp", 32'(saw), 32'd0);
        $display("txn rstB: FEQ on req2 dropped by reset");
        rr_ptr = NREQ - 1; last_c1 = '0; last_c2 = '0;
        for (int i = 0; i < NREQ; i++) begin tx1[i] = pool[i]; tx2[i] = pool[7-i]; top[i] = 2'b00; end
        run_txn('1, 1'b1, 32'd0, "rstB next");

        // Random masks, ops and operands checked against the model.
        for (int t = 0; t < 40; t++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                top[i] = 2'($urandom_range(0, 3));
                tx1[i] = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 7)];
                tx2[i] = ($urandom_range(0, 3) == 0) ? tx1[i] : pool[$urandom_range(0, 7)];
            end
            run_txn(m, 1'b1, 32'd0, $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
